instr_seq: RTL
==============

# instr_seq

Multi-cycle instruction sequencer for the 16-bit microprocessor datapath: it drives the program counter, instruction register and register-file/ALU from a FETCH/DECODE/EXEC state machine. It extends the existing three-phase control with an instruction-memory valid handshake, Z/C condition flags, conditional PC-relative branches and a halt state. It sits between `pc`, `ir` and `reg_alu` in place of the fixed ring-counter control.

## Interface
- No parameters; all widths are fixed at 16-bit instructions and 3-bit register addresses.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; low forces the reset state immediately.
- `ins_valid` in 1: the instruction word at the current `addr` is valid this cycle.
- `cur_ins` in 16: IR output, i.e. the latched instruction.
- `alu_zero` in 1: ALU result equals 0 for the current operands and op.
- `alu_cout` in 1: ALU carry-out.
- `load_ir` out 1: IR load enable.
- `pc_inc` out 1: PC += 1.
- `pc_add` out 1: PC += `pc_offset`.
- `pc_offset` out 16: sign-extended branch offset.
- `wr_reg` out 1: register-file write enable.
- `rd_addr_a` out 3: `cur_ins[2:0]`.
- `rd_addr_b` out 3: `cur_ins[5:3]`.
- `wr_addr` out 3: `cur_ins[8:6]`.
- `op` out 2: `cur_ins[10:9]`.
- `z_flag` out 1: registered zero flag.
- `c_flag` out 1: registered carry flag.
- `halted` out 1: high while in HALT.

## Operation
- Opcode class is `cur_ins[15:11]`:
  - 00000 = ALU.
  - 00001 = BZ (branch if `z_flag`).
  - 00011 = BC (branch if `c_flag`).
  - 00010 = HALT.
  - All other values = NOP.
- States: FETCH, DECODE, EXEC, HALT, encoded in 2 bits.
- FETCH:
  - Wait while `ins_valid`=0.
  - When `ins_valid`=1: `load_ir`=1 for that cycle, go to DECODE.
- DECODE: one cycle with all strobes low; the IR is now stable. Go to EXEC, or to HALT if class=00010.
- EXEC, one cycle, then FETCH:
  - ALU: `wr_reg`=1 and `pc_inc`=1. `z_flag`/`c_flag` load `alu_zero`/`alu_cout` on the same edge.
  - BZ/BC taken: `pc_add`=1 with `pc_offset` = sign-extend(`cur_ins[7:0]`), relative to the current instruction address.
  - BZ/BC not taken, or NOP: `pc_inc`=1.
  - Flags change only on ALU instructions.
- HALT:
  - All strobes stay low and `halted`=1.
  - Exit only via `reset`.
- The register address and `op` outputs are continuous decodes of `cur_ins` in every state. Only `wr_reg` qualifies a write.
- `pc_inc` and `pc_add` are never both high. `wr_reg` is never high outside EXEC.
- PC arithmetic wraps modulo 2^16; a branch offset of -128..+127 may wrap past 0 or 0xFFFF.

## Timing
- Reset (`reset`=0):
  - State goes to FETCH.
  - `z_flag`=`c_flag`=0 and `halted`=0.
  - All strobes are 0 and `pc_offset`=0.
  - This takes effect asynchronously, including mid-EXEC. An in-flight write or PC update is dropped if reset is asserted before the edge.
- The first FETCH evaluation happens on the first rising edge after `reset` goes high.
- Latency: exactly 3 cycles per instruction when `ins_valid` is already high. Each FETCH cycle with `ins_valid`=0 adds one cycle.
- All strobes are Moore outputs decoded from registered state plus `cur_ins`/flags. `load_ir` additionally gates on `ins_valid`.
- Flags written in EXEC of instruction N are visible to a branch in instruction N+1. No forwarding is needed.
- `ins_valid` is ignored outside FETCH.

## Configuration
- `INSTR_SEQ_HALT_EN`:
  - Defined: class 00010 enters HALT as described, and `halted` reflects the state.
  - Undefined: class 00010 decodes as NOP, HALT is unreachable, and `halted` is tied to 0.

## Test plan
- Reset held low with `ins_valid`=1 → state FETCH, all outputs 0. Release reset → `load_ir`=1 on the first cycle, then `wr_reg`/`pc_inc` exactly 2 cycles later for `cur_ins`=16'h0053 (ALU, op 0, wr 1, b 2, a 3).
- `ins_valid` low for 4 cycles in FETCH → no strobes for 4 cycles. The instruction then completes in 3 further cycles.
- ALU with `alu_zero`=1, followed by BZ `cur_ins`=16'h08FE → `z_flag`=1, then `pc_add`=1 with `pc_offset`=16'hFFFE and `pc_inc`=0.
- BC 16'h1805 with `c_flag`=0 → `pc_inc`=1, `pc_add`=0. Repeat with `c_flag`=1 → `pc_add`=1, `pc_offset`=16'h0005.
- HALT 16'h1000 with `INSTR_SEQ_HALT_EN` defined → `halted`=1 and no strobes for 20 cycles, until `reset` pulses low. Without the macro → `pc_inc`=1 in EXEC.
- `reset` pulsed low mid-EXEC of an ALU instruction → `wr_reg` drops immediately, flags clear, and no PC change occurs.

Source files
------------

// File: rtl/instr_seq.sv
// ============================================================================
// instr_seq -- multi-cycle instruction sequencer for the 16-bit datapath.
//
// Drives the program counter, instruction register and register-file/ALU from
// a FETCH -> DECODE -> EXEC state machine. It adds an instruction-memory valid
// handshake, registered Z/C flags, conditional PC-relative branches and an
// optional HALT state.
//
// Configuration macro: INSTR_SEQ_HALT_EN
//   defined   : class 5'b00010 enters HALT (exit only via reset), halted = state
//   undefined : class 5'b00010 decodes as NOP, halted tied to 0
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   ins_valid  in   instruction word at the current address is valid
//   cur_ins    in   [15:0] latched instruction (IR output)
//   alu_zero   in   ALU result is zero
//   alu_cout   in   ALU carry-out
//   load_ir    out  IR load enable (FETCH and ins_valid)
//   pc_inc     out  PC += 1
//   pc_add     out  PC += pc_offset
//   pc_offset  out  [15:0] sign-extended branch offset (0 unless pc_add)
//   wr_reg     out  register-file write enable (EXEC of ALU only)
//   rd_addr_a  out  [2:0] cur_ins[2:0]
//   rd_addr_b  out  [2:0] cur_ins[5:3]
//   wr_addr    out  [2:0] cur_ins[8:6]
//   op         out  [1:0] cur_ins[10:9]
//   z_flag     out  registered zero flag
//   c_flag     out  registered carry flag
//   halted     out  high while in HALT
// ============================================================================
module instr_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        ins_valid,
   input  logic [15:0] cur_ins,
   input  logic        alu_zero,
   input  logic        alu_cout,
   output logic        load_ir,
   output logic        pc_inc,
   output logic        pc_add,
   output logic [15:0] pc_offset,
   output logic        wr_reg,
   output logic [2:0]  rd_addr_a,
   output logic [2:0]  rd_addr_b,
   output logic [2:0]  wr_addr,
   output logic [1:0]  op,
   output logic        z_flag,
   output logic        c_flag,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   localparam logic [4:0] CLS_ALU  = 5'b00000;
   localparam logic [4:0] CLS_BZ   = 5'b00001;
   localparam logic [4:0] CLS_BC   = 5'b00011;
`ifdef INSTR_SEQ_HALT_EN
   localparam logic [4:0] CLS_HALT = 5'b00010;
`endif

   state_t      r_state;
   state_t      w_next;
   logic        r_z;
   logic        r_c;

   logic [4:0]  w_cls;
   logic        w_is_alu;
   logic        w_taken;
   logic        w_go_halt;
   logic [15:0] w_sext;

   // ------------------------------------------------------------------------
   // Instruction decode (continuous, valid in every state)
   // ------------------------------------------------------------------------
   assign w_cls     = cur_ins[15:11];
   assign w_is_alu  = (w_cls == CLS_ALU);
   // Branch conditions look only at the registered flags, so a flag written in
   // EXEC of the previous instruction is already visible here.
   assign w_taken   = ((w_cls == CLS_BZ) && r_z) || ((w_cls == CLS_BC) && r_c);
   assign w_sext    = {{8{cur_ins[7]}}, cur_ins[7:0]};

`ifdef INSTR_SEQ_HALT_EN
   assign w_go_halt = (w_cls == CLS_HALT);
`else
   assign w_go_halt = 1'b0;
`endif

   assign rd_addr_a = cur_ins[2:0];
   assign rd_addr_b = cur_ins[5:3];
   assign wr_addr   = cur_ins[8:6];
   assign op        = cur_ins[10:9];
   assign z_flag    = r_z;
   assign c_flag    = r_c;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (ins_valid) w_next = S_DECODE;
         S_DECODE: w_next = w_go_halt ? S_HALT : S_EXEC;
         S_EXEC:   w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (Moore on state + cur_ins/flags; load_ir also on ins_valid)
   // ------------------------------------------------------------------------
   always_comb begin
      load_ir   = 1'b0;
      pc_inc    = 1'b0;
      pc_add    = 1'b0;
      pc_offset = 16'h0000;
      wr_reg    = 1'b0;
      case (r_state)
         // reset is folded in so load_ir stays low while reset is held even
         // though the state already reads FETCH.
         S_FETCH: load_ir = ins_valid & reset;
         S_EXEC: begin
            if (w_is_alu) begin
               wr_reg = 1'b1;
               pc_inc = 1'b1;
            end else if (w_taken) begin
               pc_add    = 1'b1;
               pc_offset = w_sext;
            end else begin
               pc_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef INSTR_SEQ_HALT_EN
   assign halted = (r_state == S_HALT);
`else
   assign halted = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Condition flags: loaded only on the EXEC edge of an ALU instruction
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_z <= 1'b0;
         r_c <= 1'b0;
      end else if (r_state == S_EXEC && w_is_alu) begin
         r_z <= alu_zero;
         r_c <= alu_cout;
      end
   end

endmodule
